// File: rtl/wb_frame_fetch_pkg.sv
// Shared types for the Wishbone frame fetcher: FSM state encoding and address helpers.
package wb_frame_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Bus is word-wide; the byte offset of the start address is discarded.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_fetch_fifo.sv
// Synchronous 32-bit FIFO with count-based full/empty; head word is read straight from storage.
module wb_fetch_fifo #(
    parameter int aw = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [31:0] wr_dat,
    input  logic        rd_en,
    output logic [31:0] rd_dat,
    output logic        empty,
    output logic [aw:0] count
);
    localparam logic [aw:0] full_cnt = {1'b1, {aw{1'b0}}};

    logic [31:0]   mem [1 << aw];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty  = (count == '0);
    assign do_wr  = wr_en & (count != full_cnt);
    assign do_rd  = rd_en & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_frame_fetch.sv
// Wishbone classic read master: fetches len words from base_adr upward into a FIFO
// and streams them out on a valid/ready interface.
module wb_frame_fetch
    import wb_frame_fetch_pkg::*;
#(
    parameter int fifo_aw   = 4,
    parameter int len_width = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [len_width-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_rty_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          out_dat,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam logic [fifo_aw:0] fifo_depth = {1'b1, {fifo_aw{1'b0}}};

    fetch_state_t         state;
    logic [31:0]          adr;
    logic [len_width-1:0] remaining;
    logic                 cyc;
    logic [fifo_aw:0]     fifo_count;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic                 room;

    assign room     = (fifo_count < fifo_depth);
    // cyc is only ever high in REQ, so it qualifies the termination inputs.
    assign fifo_wr  = cyc & wb_ack_i & ~wb_err_i;

    assign wb_adr_o  = adr;
    assign wb_dat_o  = 32'h0;
    assign wb_we_o   = 1'b0;
    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = cyc;
    assign wb_sel_o  = cyc ? 4'hF : 4'h0;
    assign out_valid = ~fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            adr       <= '0;
            remaining <= '0;
            cyc       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            adr       <= word_align(base_adr);
                            remaining <= len;
                            busy      <= 1'b1;
                            state     <= ST_WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (room) begin
                        cyc   <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wb_err_i) begin
                        cyc   <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        cyc       <= 1'b0;
                        adr       <= adr + WORD_BYTES;
                        remaining <= remaining - 1'b1;
                        if (remaining == len_width'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (wb_rty_i) begin
                        cyc   <= 1'b0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The gap cycle doubles as the room check so a free FIFO sees one
                    // word per two clocks; only a full FIFO parks the FSM in WAIT.
                    if (room) begin
                        cyc   <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_fetch_fifo #(
        .aw(fifo_aw)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (fifo_wr),
        .wr_dat (wb_dat_i),
        .rd_en  (out_ready),
        .rd_dat (out_dat),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_wb_frame_fetch.sv
// Directed bench for wb_frame_fetch: scripted Wishbone slave plus stream consumer.
module tb_wb_frame_fetch;
    import wb_frame_fetch_pkg::*;

    localparam logic [31:0] DKEY = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] len;
    logic        busy, done, err;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0] wb_dat_i;
    logic [31:0] out_dat;
    logic        out_valid, out_ready;

    int checks = 0;
    int failures = 0;

    int attempts, rx_n, done_cnt, err_cnt, err_at, rty_from, rty_cnt;
    logic [31:0] adr_log [64];
    logic [31:0] rx [64];

    wb_frame_fetch #(.fifo_aw(4), .len_width(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_adr(base_adr), .len(len),
        .busy(busy), .done(done), .err(err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slave and consumer monitor; bus outputs are registered so negedge is stable.
    always @(negedge clk) begin
        wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        if (wb_cyc_o && wb_stb_o) begin
            if (attempts < 64) adr_log[attempts] = wb_adr_o;
            if (attempts == err_at) wb_err_i = 1'b1;
            else if (attempts >= rty_from && attempts < rty_from + rty_cnt) wb_rty_i = 1'b1;
            else begin
                wb_ack_i = 1'b1;
                wb_dat_i = wb_adr_o ^ DKEY;
            end
            attempts++;
        end
        if (out_valid && out_ready) begin
            if (rx_n < 64) rx[rx_n] = out_dat;
            rx_n++;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic clear_stats();
        attempts = 0; rx_n = 0; done_cnt = 0; err_cnt = 0;
        err_at = -1; rty_from = -1; rty_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_adr = a; len = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt == 0 && err_cnt == 0) begin
            failures++;
            $display("FAIL job_end: no done/err pulse within %0d cycles", budget);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_rx(input string name, input logic [31:0] first, input int n);
        for (int i = 0; i < n && i < 64; i++) begin
            checks++;
            if (rx[i] !== ((first + 32'(4 * i)) ^ DKEY)) begin
                failures++;
                $display("FAIL %s word %0d: got %h expected %h", name, i, rx[i], (first + 32'(4 * i)) ^ DKEY);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base_adr = '0; len = '0; out_ready = 1'b1;
        clear_stats();
        #23;
        checks++; if ({busy, done, err, wb_cyc_o, wb_stb_o, out_valid} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, err, wb_cyc_o, wb_stb_o, out_valid}); end
        checks++; if (wb_adr_o !== 32'h0) begin failures++; $display("FAIL reset_adr: got %h expected 0", wb_adr_o); end
        checks++; if (wb_sel_o !== 4'h0) begin failures++; $display("FAIL reset_sel: got %h expected 0", wb_sel_o); end
        reset_n = 1'b1;
        idle_cycles(3);
        checks++; if ({busy, wb_cyc_o, out_valid, wb_we_o} !== 4'b0 || wb_dat_o !== 32'h0) begin failures++; $display("FAIL post_reset_idle: got busy/cyc/valid/we %b dat_o %h expected 0", {busy, wb_cyc_o, out_valid, wb_we_o}, wb_dat_o); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_a [4];
        exp_a = '{32'h4000_0100, 32'h4000_0104, 32'h4000_0108, 32'h4000_010C};
        clear_stats();
        out_ready = 1'b1;
        pulse_start(32'h4000_0100, 16'd4);
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1 || wb_cyc_o !== 1'b0) begin failures++; $display("FAIL basic_wait_cycle: got busy %b cyc %b expected 1 0", busy, wb_cyc_o); end
        @(negedge clk); #1;
        checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) begin failures++; $display("FAIL basic_first_cyc: got cyc %b stb %b sel %h expected 1 1 f", wb_cyc_o, wb_stb_o, wb_sel_o); end
        checks++; if (wb_adr_o !== 32'h4000_0100) begin failures++; $display("FAIL basic_first_adr: got %h expected 40000100", wb_adr_o); end
        @(negedge clk); #1;
        checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL basic_gap: got cyc %b expected 0", wb_cyc_o); end
        // A start during the job must be ignored.
        pulse_start(32'h0000_0000, 16'd9);
        wait_end(100);
        idle_cycles(6);
        checks++; if (attempts !== 4) begin failures++; $display("FAIL basic_reads: got %0d expected 4", attempts); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (adr_log[i] !== exp_a[i]) begin failures++; $display("FAIL basic_adr %0d: got %h expected %h", i, adr_log[i], exp_a[i]); end
        end
        checks++; if (rx_n !== 4) begin failures++; $display("FAIL basic_rx_count: got %0d expected 4", rx_n); end
        check_rx("basic_rx", 32'h4000_0100, 4);
        checks++; if (done_cnt !== 1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done: got done_cnt %0d busy %b expected 1 0", done_cnt, busy); end
    endtask

    task automatic test_len_zero();
        clear_stats();
        pulse_start(32'h0000_1000, 16'd0);
        @(negedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL len0_done: got done %b busy %b expected 1 0", done, busy); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL len0_pulse_width: got done %b expected 0", done); end
        idle_cycles(6);
        checks++; if (attempts !== 0 || busy !== 1'b0 || done_cnt !== 1) begin failures++; $display("FAIL len0_quiet: got reads %0d busy %b done_cnt %0d expected 0 0 1", attempts, busy, done_cnt); end
    endtask

    task automatic test_backpressure();
        clear_stats();
        out_ready = 1'b0;
        pulse_start(32'h0000_2000, 16'd40);
        idle_cycles(100);
        checks++; if (attempts !== 16) begin failures++; $display("FAIL bp_fill_reads: got %0d expected 16", attempts); end
        checks++; if (wb_cyc_o !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall: got cyc %b busy %b valid %b expected 0 1 1", wb_cyc_o, busy, out_valid); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_end(400);
        idle_cycles(25);
        checks++; if (rx_n !== 40 || attempts !== 40) begin failures++; $display("FAIL bp_totals: got rx %0d reads %0d expected 40 40", rx_n, attempts); end
        check_rx("bp_rx", 32'h0000_2000, 40);
        checks++; if (done_cnt !== 1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_end: got done_cnt %0d valid %b expected 1 0", done_cnt, out_valid); end
    endtask

    task automatic test_retry();
        logic [31:0] exp_a [6];
        exp_a = '{32'h100, 32'h104, 32'h104, 32'h104, 32'h108, 32'h10C};
        clear_stats();
        rty_from = 1; rty_cnt = 2;
        pulse_start(32'h0000_0100, 16'd4);
        wait_end(100);
        idle_cycles(6);
        checks++; if (attempts !== 6) begin failures++; $display("FAIL rty_reads: got %0d expected 6", attempts); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (adr_log[i] !== exp_a[i]) begin failures++; $display("FAIL rty_adr %0d: got %h expected %h", i, adr_log[i], exp_a[i]); end
        end
        checks++; if (rx_n !== 4 || done_cnt !== 1) begin failures++; $display("FAIL rty_totals: got rx %0d done_cnt %0d expected 4 1", rx_n, done_cnt); end
        check_rx("rty_rx", 32'h0000_0100, 4);
    endtask

    task automatic test_error();
        clear_stats();
        err_at = 2;
        pulse_start(32'h0000_0200, 16'd8);
        wait_end(100);
        idle_cycles(15);
        checks++; if (err_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL err_pulses: got err_cnt %0d done_cnt %0d expected 1 0", err_cnt, done_cnt); end
        checks++; if (attempts !== 3 || busy !== 1'b0 || wb_cyc_o !== 1'b0) begin failures++; $display("FAIL err_idle: got reads %0d busy %b cyc %b expected 3 0 0", attempts, busy, wb_cyc_o); end
        checks++; if (rx_n !== 2) begin failures++; $display("FAIL err_rx_count: got %0d expected 2", rx_n); end
        check_rx("err_rx", 32'h0000_0200, 2);
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] exp_a [3];
        int n;
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        clear_stats();
        pulse_start(32'hFFFF_FFFB, 16'd3);
        wait_end(100);
        idle_cycles(6);
        for (int i = 0; i < 3; i++) begin
            checks++; if (adr_log[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_adr %0d: got %h expected %h", i, adr_log[i], exp_a[i]); end
        end
        checks++; if (rx_n !== 3 || rx[2] !== (32'h0 ^ DKEY)) begin failures++; $display("FAIL wrap_rx: got count %0d last %h expected 3 %h", rx_n, rx[2], DKEY); end

        clear_stats();
        out_ready = 1'b0;
        pulse_start(32'h0000_0300, 16'd4);
        n = 0;
        while (attempts < 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (wb_cyc_o !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL arst_setup: got cyc %b valid %b expected 1 1", wb_cyc_o, out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, out_valid, busy} !== 4'b0) begin failures++; $display("FAIL arst_drop: got cyc/stb/valid/busy %b expected 0000", {wb_cyc_o, wb_stb_o, out_valid, busy}); end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(4);
        checks++; if ({wb_cyc_o, out_valid, busy} !== 3'b0) begin failures++; $display("FAIL arst_idle: got cyc/valid/busy %b expected 000", {wb_cyc_o, out_valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_backpressure();
        test_retry();
        test_error();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
